// File: rtl/hyster_window_ctrl.sv
// Window sequencer for the hysteresis edge stage: two line buffers feed a 3x3 window per pixel,
// and the unit's late edge bit is re-framed. Optional macro HYST_FORCE_BORDER_EN forces border edges to 1.
module hyster_window_ctrl #(
    parameter int DSIZE = 4,
    parameter int MAX_W = 640,
    parameter int XW    = 10,
    parameter int YW    = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [XW-1:0]      i_width,
    input  logic [YW-1:0]      i_height,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [DSIZE-1:0]   i_in_pixel,
    output logic [DSIZE*9-1:0] o_win,
    output logic               o_win_valid,
    input  logic               i_edge,
    output logic               o_edge,
    output logic               o_edge_valid,
    output logic               o_edge_last,
    output logic               o_busy,
    output logic               o_done
);
    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {IDLE, RUN, STALL, FLUSH, DONE} state_t;
    typedef struct packed {
        logic [DSIZE-1:0] top;
        logic [DSIZE-1:0] mid;
        logic [DSIZE-1:0] bot;
    } col_t;

    state_t           state, nxt;
    logic [XW-1:0]    w_q, x_q, fx_q, rd_x;
    logic [YW-1:0]    h_q, y_q;
    logic [AW-1:0]    rd_a;
    logic             in_end_q;
    col_t             c1_q, c2_q, new_col, left_col;
    logic [DSIZE-1:0] lb_a [MAX_W];
    logic [DSIZE-1:0] lb_b [MAX_W];
    logic             start_ok, acc, emit, last, x_end, y_end;
    logic [1:0]       vld_pipe, last_pipe;
    logic [DSIZE*9-1:0] win_q;
    logic             done_q, busy_q;

    assign start_ok = i_start && (i_width >= XW'(2)) && (i_width <= XW'(MAX_W)) &&
                      (i_height >= YW'(2));
    assign x_end    = (x_q == w_q - XW'(1));
    assign y_end    = (y_q == h_q - YW'(1));
    assign acc      = (state == RUN) && i_in_valid;
    assign rd_x     = (state == FLUSH) ? fx_q + XW'(1) : x_q;
    assign rd_a     = rd_x[AW-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= nxt;
    end

    // c1/c2 hold the two previous columns; new_col is the column entering the window.
    always_comb begin
        nxt      = state;
        new_col  = '0;
        left_col = c2_q;
        emit     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: if (start_ok) nxt = RUN;
            RUN: begin
                new_col.top = (y_q == YW'(1)) ? '0 : lb_a[rd_a];
                new_col.mid = lb_b[rd_a];
                new_col.bot = i_in_pixel;
                if (x_q == XW'(1)) left_col = '0;
                emit = acc && (x_q != '0) && (y_q != '0);
                if (acc && x_end && (y_q != '0)) nxt = STALL;
            end
            STALL: begin
                emit = 1'b1;
                nxt  = in_end_q ? FLUSH : RUN;
            end
            FLUSH: begin
                emit = 1'b1;
                last = (fx_q == w_q - XW'(1));
                if (!last) begin
                    new_col.top = lb_a[rd_a];
                    new_col.mid = lb_b[rd_a];
                end else begin
                    nxt = DONE;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Line buffer contents never need clearing: padding comes from the coordinates.
    always_ff @(posedge i_clk) begin
        if (acc) begin
            lb_a[rd_a] <= lb_b[rd_a];
            lb_b[rd_a] <= i_in_pixel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            fx_q      <= '0;
            in_end_q  <= 1'b0;
            c1_q      <= '0;
            c2_q      <= '0;
            win_q     <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (state == IDLE && start_ok) begin
                w_q      <= i_width;
                h_q      <= i_height;
                x_q      <= '0;
                y_q      <= '0;
                in_end_q <= 1'b0;
                busy_q   <= 1'b1;
            end else if (done_q && state == IDLE) begin
                busy_q <= 1'b0;
            end
            if (acc) begin
                if (x_end) begin
                    x_q <= '0;
                    if (y_end) in_end_q <= 1'b1;
                    else       y_q      <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
            if (acc || state == FLUSH) begin
                c2_q <= c1_q;
                c1_q <= new_col;
            end else if (state == STALL && in_end_q) begin
                // Prime the flush: left pad plus column 0 of the last row pair.
                c2_q     <= '0;
                c1_q.top <= lb_a[0];
                c1_q.mid <= lb_b[0];
                c1_q.bot <= '0;
                fx_q     <= '0;
            end
            if (state == FLUSH) fx_q <= fx_q + XW'(1);
            if (emit)
                win_q <= {left_col.top, c1_q.top, new_col.top,
                          left_col.mid, c1_q.mid, new_col.mid,
                          left_col.bot, c1_q.bot, new_col.bot};
            vld_pipe  <= {vld_pipe[0], emit};
            last_pipe <= {last_pipe[0], last};
            done_q    <= last_pipe[1];
        end
    end

    assign o_in_ready   = (state == RUN);
    assign o_win        = win_q;
    assign o_win_valid  = vld_pipe[0];
    assign o_edge_valid = vld_pipe[1];
    assign o_edge_last  = last_pipe[1];
    assign o_busy       = busy_q;
    assign o_done       = done_q;

`ifdef HYST_FORCE_BORDER_EN
    logic       bord;
    logic [1:0] bord_pipe;
    // Accept-phase centers are (x-1,y-1); stall and flush centers are always on the border.
    assign bord = (state != RUN) || (x_q == XW'(1)) || (y_q == YW'(1));
    always_ff @(posedge i_clk) begin
        if (i_rst) bord_pipe <= '0;
        else       bord_pipe <= {bord_pipe[0], bord};
    end
    assign o_edge = o_edge_valid & (bord_pipe[1] | i_edge);
`else
    assign o_edge = o_edge_valid & i_edge;
`endif

endmodule

// File: tb/tb_hyster_window_ctrl.sv
// Self-checking bench for hyster_window_ctrl: vector table, corner sequences and random frames
// checked against a coordinate-level window/edge model.
`timescale 1ns/1ps
module tb_hyster_window_ctrl;
    localparam int DS = 4, MW = 640, XW = 10, YW = 10, WB = DS * 9;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_in_valid, o_in_ready;
    logic [XW-1:0] i_width;
    logic [YW-1:0] i_height;
    logic [DS-1:0] i_in_pixel;
    logic [WB-1:0] o_win;
    logic          o_win_valid, o_edge, o_edge_valid, o_edge_last, o_busy, o_done;
    logic          i_edge = 1'b0;

    always #5 clk = ~clk;

    hyster_window_ctrl #(.DSIZE(DS), .MAX_W(MW), .XW(XW), .YW(YW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_width(i_width), .i_height(i_height),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_pixel(i_in_pixel),
        .o_win(o_win), .o_win_valid(o_win_valid), .i_edge(i_edge), .o_edge(o_edge),
        .o_edge_valid(o_edge_valid), .o_edge_last(o_edge_last), .o_busy(o_busy), .o_done(o_done));

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DS-1:0] img [0:4095];
    int edge_mode = 0;  // 0: unit outputs 0, 1: unit outputs 1, 2: unit outputs XOR of window bits

    function automatic logic [WB-1:0] model_win(input int w, input int h, input int cx, input int cy);
        logic [WB-1:0] r = '0;
        for (int k = 0; k < 9; k++) begin
            int px = cx + (k % 3) - 1;
            int py = cy + (k / 3) - 1;
            if (px >= 0 && px < w && py >= 0 && py < h) r[WB-1-k*DS -: DS] = img[py*w + px];
        end
        return r;
    endfunction

    function automatic logic hyst(input logic [WB-1:0] win);
        if (edge_mode == 0) return 1'b0;
        if (edge_mode == 1) return 1'b1;
        return ^win;
    endfunction

    function automatic logic model_edge(input int w, input int h, input int cx, input int cy);
`ifdef HYST_FORCE_BORDER_EN
        if (cx == 0 || cx == w-1 || cy == 0 || cy == h-1) return 1'b1;
`endif
        return hyst(model_win(w, h, cx, cy));
    endfunction

    // ---------------- monitor + hysteresis stand-in ----------------
    logic [WB-1:0] win_cap[$];
    logic          edge_cap[$];
    int cyc = 0, last_cnt = 0, last_idx = -1, last_cyc = 0, done_cnt = 0, done_cyc = 0;
    logic done_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (o_win_valid) win_cap.push_back(o_win);
        if (o_edge_valid) begin
            edge_cap.push_back(o_edge);
            if (o_edge_last) begin
                last_cnt++;
                last_idx = edge_cap.size() - 1;
                last_cyc = cyc;
            end
        end
        if (o_done) begin
            done_cnt++;
            done_cyc  = cyc;
            done_busy = o_busy;
        end
        // result for this window appears one cycle later, as the real unit does
        i_edge = o_win_valid ? hyst(o_win) : 1'b0;
    end

    task automatic clear_cap();
        win_cap.delete();
        edge_cap.delete();
        last_cnt = 0; last_idx = -1; last_cyc = 0; done_cnt = 0; done_cyc = 0; done_busy = 1'b0;
    endtask

    task automatic pulse_start(input int w, input int h);
        i_start = 1'b1; i_width = XW'(w); i_height = YW'(h);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic fill_img(input int w, input int h, input int fill);
        for (int i = 0; i < w*h; i++)
            img[i] = (fill == 0) ? '0 : (fill == 1) ? DS'(3*(i/w) + (i%w)) : DS'($urandom_range(0, 15));
    endtask

    // gap: 0 continuous, 1 valid every other cycle, 2 random valid
    task automatic drive_frame(input int w, input int h, input int gap, output int stalls);
        int idx = 0, n = 0;
        logic ph = 1'b1, v, acc;
        stalls = 0;
        while (idx < w*h && n < 5000) begin
            v = (gap == 0) ? 1'b1 : (gap == 1) ? ph : ($urandom_range(0, 1) == 1);
            ph = ~ph;
            i_in_valid = v; i_in_pixel = img[idx];
            if (!o_in_ready) stalls++;
            acc = v && o_in_ready;
            @(negedge clk); n++;
            if (acc) idx++;
        end
        i_in_valid = 1'b0; i_in_pixel = '0;
        if (!o_in_ready) stalls++;  // stall that follows the final accept
        check("input_accepted", idx, w*h);
    endtask

    task automatic run_frame(input int w, input int h, input int gap, input int fill,
                             input int em, output int stalls);
        int t = 0, nw, ne;
        edge_mode = em;
        fill_img(w, h, fill);
        clear_cap();
        pulse_start(w, h);
        check("busy_after_start", o_busy, 1);
        drive_frame(w, h, gap, stalls);
        do begin
            @(negedge clk); #1; t++;
        end while (done_cnt == 0 && t < 3000);
        check("done_seen", done_cnt, 1);
        check("busy_in_done", done_busy, 1);
        @(negedge clk);
        check("busy_after_done", o_busy, 0);
        check("win_count", win_cap.size(), w*h);
        check("edge_count", edge_cap.size(), w*h);
        nw = (win_cap.size() < w*h) ? win_cap.size() : w*h;
        ne = (edge_cap.size() < w*h) ? edge_cap.size() : w*h;
        for (int k = 0; k < nw; k++)
            check($sformatf("win(%0d,%0d) %0dx%0d", k%w, k/w, w, h), win_cap[k], model_win(w, h, k%w, k/w));
        for (int k = 0; k < ne; k++)
            check($sformatf("edge(%0d,%0d) %0dx%0d", k%w, k/w, w, h), edge_cap[k], model_edge(w, h, k%w, k/w));
        check("edge_last_count", last_cnt, 1);
        check("edge_last_index", last_idx, w*h - 1);
        check("done_after_last", done_cyc - last_cyc, 1);
    endtask

    typedef struct {
        int w; int h; int gap; int fill; int em;
        int exp_n; int exp_stalls; int probe; logic [WB-1:0] exp_probe;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        logic [8:0] eg, eexp;
        tbl[0] = '{4, 3, 0, 0, 1, 12, 2, 11, 36'h0};
        tbl[1] = '{3, 3, 0, 1, 2,  9, 2,  4, 36'h012345678};
        tbl[2] = '{3, 3, 0, 1, 2,  9, 2,  0, 36'h000001034};
        tbl[3] = '{3, 3, 1, 1, 2,  9, 2,  8, 36'h450780000};
        tbl[4] = '{2, 2, 0, 1, 2,  4, 1,  3, 36'h010340000};

        i_rst = 1'b1; i_start = 1'b0; i_width = '0; i_height = '0;
        i_in_valid = 1'b0; i_in_pixel = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", o_in_ready, 0);
        check("rst_win", o_win, 0);
        check("rst_win_valid", o_win_valid, 0);
        check("rst_edge_valid", o_edge_valid, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        i_rst = 1'b0;
        @(negedge clk);

        // illegal starts are ignored
        clear_cap();
        pulse_start(1, 3);
        repeat (3) @(negedge clk);
        check("illegal_w1_busy", o_busy, 0);
        check("illegal_w1_ready", o_in_ready, 0);
        pulse_start(MW + 1, 3);
        repeat (3) @(negedge clk);
        check("illegal_wmax_busy", o_busy, 0);
        check("illegal_wmax_ready", o_in_ready, 0);
        pulse_start(4, 1);
        repeat (3) @(negedge clk);
        check("illegal_h1_busy", o_busy, 0);
        check("illegal_no_windows", win_cap.size(), 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].w, tbl[i].h, tbl[i].gap, tbl[i].fill, tbl[i].em, st);
            check($sformatf("tbl%0d_nwin", i), win_cap.size(), tbl[i].exp_n);
            check($sformatf("tbl%0d_stalls", i), st, tbl[i].exp_stalls);
            if (win_cap.size() > tbl[i].probe)
                check($sformatf("tbl%0d_probe", i), win_cap[tbl[i].probe], tbl[i].exp_probe);
            else
                check($sformatf("tbl%0d_probe_missing", i), win_cap.size(), tbl[i].probe + 1);
        end

        // border forcing with the unit always answering 0
        run_frame(3, 3, 0, 1, 0, st);
        eg = '0;
        for (int k = 0; k < 9 && k < edge_cap.size(); k++) eg[8-k] = edge_cap[k];
`ifdef HYST_FORCE_BORDER_EN
        eexp = 9'b111101111;
`else
        eexp = 9'b000000000;
`endif
        check("border_edges", eg, eexp);

        // reset mid-frame abandons it
        clear_cap();
        edge_mode = 2;
        fill_img(4, 3, 1);
        pulse_start(4, 3);
        for (int i = 0; i < 5; i++) begin
            i_in_valid = 1'b1; i_in_pixel = img[i];
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        check("midframe_busy", o_busy, 1);
        i_rst = 1'b1;
        @(negedge clk);
        i_rst = 1'b0;
        check("mrst_ready", o_in_ready, 0);
        check("mrst_win", o_win, 0);
        check("mrst_win_valid", o_win_valid, 0);
        check("mrst_edge", o_edge, 0);
        check("mrst_edge_valid", o_edge_valid, 0);
        check("mrst_edge_last", o_edge_last, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_done", o_done, 0);
        repeat (20) @(negedge clk);
        check("mrst_no_done", done_cnt, 0);
        run_frame(4, 3, 0, 2, 2, st);
        check("mrst_clean_stalls", st, 2);

        // random frames
        for (int r = 0; r < 8; r++) begin
            int w = $urandom_range(2, 12);
            int h = $urandom_range(2, 8);
            run_frame(w, h, $urandom_range(0, 2), 2, 2, st);
            check($sformatf("rand%0d_stalls", r), st, h - 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
